pamac_ap_ctrl: RTL and testbench

PAMAC_AP_CTRL -- requirements
Module: pamac_ap_ctrl

---
 rtl/pamac_ctrl_pkg.sv | 28 ++
 rtl/pamac_ap_ctrl_booth_r4_encoder.sv | 34 +++
 rtl/pamac_ap_ctrl.sv | 138 +++++++++++++
 tb/tb_pamac_ap_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pamac_ctrl_pkg.sv
// Shared types for the PAMAC radix-4 Booth controller.
// Holds the FSM state enum, the per-digit field and the recoding helper.
package pamac_ctrl_pkg;

    localparam int L_MULT_DEF = 16;
    localparam int SHIFT_W    = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic nz;
        logic neg;
        logic dbl;
    } digit_t;

    // Triple is {b[2k+1], b[2k], b[2k-1]}.
    function automatic digit_t booth_digit(input logic [2:0] i_t);
        digit_t d;
        d.nz  = (i_t != 3'b000) && (i_t != 3'b111);
        d.neg = i_t[2] && d.nz;
        d.dbl = (i_t == 3'b011) || (i_t == 3'b100);
        return d;
    endfunction

endpackage

// File: rtl/pamac_ap_ctrl_booth_r4_encoder.sv
// Combinational radix-4 Booth recoder.
// Produces per-digit nonzero, negate and double flags.
module booth_r4_encoder
    import pamac_ctrl_pkg::*;
#(
    parameter int L_MULT = L_MULT_DEF
) (
    input  logic [L_MULT-1:0]   i_mult,
    output logic [L_MULT/2-1:0] o_nz,
    output logic [L_MULT/2-1:0] o_neg,
    output logic [L_MULT/2-1:0] o_dbl
);

    localparam int ND = L_MULT / 2;

    logic [L_MULT:0] w_ext;
    digit_t          w_d;

    assign w_ext = {i_mult, 1'b0};

    always_comb begin
        o_nz  = '0;
        o_neg = '0;
        o_dbl = '0;
        w_d   = '0;
        for (int k = 0; k < ND; k++) begin
            w_d      = booth_digit(w_ext[2*k +: 3]);
            o_nz[k]  = w_d.nz;
            o_neg[k] = w_d.neg;
            o_dbl[k] = w_d.dbl;
        end
    end

endmodule

// File: rtl/pamac_ap_ctrl.sv
// PAMAC controller: issues nonzero Booth digits one per cycle
// to a shift/add datapath, with back-to-back operation acceptance.
module pamac_ap_ctrl
    import pamac_ctrl_pkg::*;
#(
    parameter int L_MULT = L_MULT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [L_MULT-1:0] i_mult,
    input  logic              i_mul_sel_in,
    output logic              o_mul_sel,
    output logic [SHIFT_W-1:0] o_shift_ctrl,
    output logic              o_double,
    output logic              o_neg,
    output logic              o_first_cycle,
    output logic              o_dff_en,
    output logic              o_res_valid,
    output logic              o_busy
);

    localparam int             ND  = L_MULT / 2;
    localparam logic [ND-1:0]  LSB = ND'(1);

    state_t              r_state;
    state_t              w_state_nx;
    logic [ND-1:0]       r_mask;
    logic [ND-1:0]       r_neg;
    logic [ND-1:0]       r_dbl;
    logic                r_zero;
    logic                r_first;
    logic                r_mul_sel;

    logic [ND-1:0]       w_enc_nz;
    logic [ND-1:0]       w_enc_neg;
    logic [ND-1:0]       w_enc_dbl;
    logic [ND-1:0]       w_onehot;
    logic [SHIFT_W-1:0]  w_idx;
    logic                w_issue;
    logic                w_last;
    logic                w_accept;
    logic                w_enc_zero;

    booth_r4_encoder #(
        .L_MULT (L_MULT)
    ) u_enc (
        .i_mult (i_mult),
        .o_nz   (w_enc_nz),
        .o_neg  (w_enc_neg),
        .o_dbl  (w_enc_dbl)
    );

    // Lowest pending digit wins.
    always_comb begin
        w_idx    = '0;
        w_onehot = '0;
        for (int i = ND - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_idx       = SHIFT_W'(i);
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_issue    = (r_state == ST_RUN);
    assign w_last     = w_issue && !r_zero
                        && ((r_mask & ~w_onehot) == '0);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_enc_zero = (w_enc_nz == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last && !w_accept) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready    = (r_state == ST_IDLE) || w_last;
        o_busy        = w_issue;
        o_dff_en      = w_issue;
        o_shift_ctrl  = w_issue ? w_idx : '0;
        o_neg         = w_issue && |(r_neg & w_onehot);
        o_double      = w_issue && |(r_dbl & w_onehot);
        o_first_cycle = w_issue && r_first;
        o_res_valid   = w_last;
        o_mul_sel     = r_mul_sel;
    end

    // A zero multiplier becomes +x then -x on digit 0 so Y still equals T.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask    <= '0;
            r_neg     <= '0;
            r_dbl     <= '0;
            r_zero    <= 1'b0;
            r_first   <= 1'b0;
            r_mul_sel <= 1'b0;
        end else if (w_accept) begin
            r_mask    <= w_enc_zero ? LSB : w_enc_nz;
            r_neg     <= w_enc_neg;
            r_dbl     <= w_enc_dbl;
            r_zero    <= w_enc_zero;
            r_first   <= 1'b1;
            r_mul_sel <= i_mul_sel_in;
        end else if (w_issue) begin
            r_first <= 1'b0;
            if (r_zero) begin
                r_zero   <= 1'b0;
                r_neg[0] <= 1'b1;
            end else begin
                r_mask <= r_mask & ~w_onehot;
            end
        end
    end

endmodule

// File: tb/tb_pamac_ap_ctrl.sv
// Directed bench for pamac_ap_ctrl with a small shift/add model
// that turns the issued controls into Y for result checks.
module tb_pamac_ap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] mult = '0;
    logic        sel_in = 1'b0;
    logic        mul_sel;
    logic [2:0]  shift_ctrl;
    logic        dbl;
    logic        neg;
    logic        first_cycle;
    logic        dff_en;
    logic        res_valid;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    int acc = 0;
    int a_op = 0;
    int t_op = 0;

    always #5 clk = ~clk;

    pamac_ap_ctrl #(
        .L_MULT (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_mult        (mult),
        .i_mul_sel_in  (sel_in),
        .o_mul_sel     (mul_sel),
        .o_shift_ctrl  (shift_ctrl),
        .o_double      (dbl),
        .o_neg         (neg),
        .o_first_cycle (first_cycle),
        .o_dff_en      (dff_en),
        .o_res_valid   (res_valid),
        .o_busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input int k, input int ng,
                        input int db, input int fc, input int rv,
                        input int rdy, input bit chk_y, input int ey);
        int base;
        int term;
        int y;
        @(negedge clk);
        chk({tag, ".dff"}, 32'(dff_en), 1);
        chk({tag, ".busy"}, 32'(busy), 1);
        chk({tag, ".k"}, 32'(shift_ctrl), k);
        chk({tag, ".neg"}, 32'(neg), ng);
        chk({tag, ".dbl"}, 32'(dbl), db);
        chk({tag, ".first"}, 32'(first_cycle), fc);
        chk({tag, ".rv"}, 32'(res_valid), rv);
        chk({tag, ".rdy"}, 32'(in_ready), rdy);
        base = first_cycle ? t_op : acc;
        term = a_op <<< (2 * int'(shift_ctrl));
        if (dbl) term = term * 2;
        if (neg) term = -term;
        y = base + term;
        acc = y;
        if (chk_y) chk({tag, ".y"}, y, ey);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_chk(input string tag, input int ms);
        @(negedge clk);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".dff"}, 32'(dff_en), 0);
        chk({tag, ".rv"}, 32'(res_valid), 0);
        chk({tag, ".k"}, 32'(shift_ctrl), 0);
        chk({tag, ".ctl"}, 32'({neg, dbl, first_cycle}), 0);
        chk({tag, ".rdy"}, 32'(in_ready), 1);
        chk({tag, ".sel"}, 32'(mul_sel), ms);
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] m, input logic s);
        in_valid = 1'b1;
        mult     = m;
        sel_in   = s;
        @(negedge clk);
        chk("offer.rdy", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.dff", 32'(dff_en), 0);
        chk("rst.rv", 32'(res_valid), 0);
        chk("rst.sel", 32'(mul_sel), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_chk("post_rst", 0);

        a_op = 5; t_op = 0;
        offer(16'h0003, 1'b1);
        step("m3c1", 0, 1, 0, 1, 0, 0, 0, 0);
        step("m3c2", 1, 0, 0, 0, 1, 1, 1, 15);
        idle_chk("m3idle", 1);

        a_op = 7; t_op = 32'h1234;
        offer(16'h0000, 1'b0);
        step("m0c1", 0, 0, 0, 1, 0, 0, 0, 0);
        step("m0c2", 0, 1, 0, 0, 1, 1, 1, 32'h1234);
        idle_chk("m0idle", 0);

        a_op = 1; t_op = 0;
        offer(16'h8000, 1'b1);
        step("m8000", 7, 1, 1, 1, 1, 1, 1, -32768);
        idle_chk("m8idle", 1);

        a_op = 3; t_op = 10;
        offer(16'h5555, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                mult     = 16'h8000;
            end
            step($sformatf("m5555c%0d", i + 1), i, 0, 0,
                 int'(i == 0), int'(i == 7), int'(i == 7),
                 1, 10 + 3 * (32'h5555 & ((32'h4 << (2 * i)) - 1)));
        end
        idle_chk("m5idle", 0);

        a_op = 9; t_op = 100;
        offer(16'hFFFF, 1'b0);
        step("mffff", 0, 1, 0, 1, 1, 1, 1, 91);
        idle_chk("mfidle", 0);

        a_op = 5; t_op = 0;
        offer(16'h0003, 1'b0);
        step("b2bc1", 0, 1, 0, 1, 0, 0, 0, 0);
        in_valid = 1'b1;
        mult     = 16'h0001;
        sel_in   = 1'b1;
        step("b2bc2", 1, 0, 0, 0, 1, 1, 1, 15);
        step("b2bc3", 0, 0, 0, 1, 1, 1, 1, 5);
        idle_chk("b2bidle", 1);

        a_op = 1; t_op = 0;
        offer(16'h5555, 1'b0);
        step("rstc1", 0, 0, 0, 1, 0, 0, 0, 0);
        step("rstc2", 1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstc3.k", 32'(shift_ctrl), 2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstx.busy", 32'(busy), 0);
        chk("rstx.dff", 32'(dff_en), 0);
        chk("rstx.rv", 32'(res_valid), 0);
        chk("rstx.rdy", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        idle_chk("rstidle1", 0);
        idle_chk("rstidle2", 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
